sum_block_accumulator: RTL and testbench



---
 rtl/adder_pkg.sv | 22 ++
 rtl/sum_block_accumulator_if.sv | 31 +++
 rtl/sum_block_accumulator.sv | 118 +++++++++++
 tb/tb_sum_block_accumulator.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and constants for the adder and its block accumulator
//
// Contents:
//   DATA_WIDTH_DEFAULT  default operand width, shared with the upstream adder
//   acc_state_t         output stage state (ST_EMPTY / ST_FULL)
//   sum_width()         block total width for a given operand width and block length
package adder_pkg;

  localparam int DATA_WIDTH_DEFAULT = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } acc_state_t;

  // An adder result is data_width+1 bits; summing block_len of them needs
  // $clog2(block_len) extra bits of headroom.
  function automatic int sum_width(input int data_width, input int block_len);
    return data_width + 1 + $clog2(block_len);
  endfunction

endpackage

// File: rtl/sum_block_accumulator_if.sv
// rtl/sum_block_accumulator_if.sv - sum input stream and block total output handshake
//
// Signals (named from the accumulator's point of view):
//   i_valid  input sum valid (from adder o_valid)
//   i_C      input sum, g_data_width+1 bits (from adder o_C)
//   i_ready  downstream accepts o_sum this cycle
//   o_valid  o_sum holds an unaccepted block total
//   o_sum    block total, g_sum_width bits
// Modports: slave = accumulator side, master = producer/consumer side.
interface sum_block_accumulator_if #(
  parameter int g_data_width = 3,
  parameter int g_sum_width  = 6
);

  logic                    i_valid;
  logic [g_data_width:0]   i_C;
  logic                    i_ready;
  logic                    o_valid;
  logic [g_sum_width-1:0]  o_sum;

  modport master (
    output i_valid, i_C, i_ready,
    input  o_valid, o_sum
  );

  modport slave (
    input  i_valid, i_C, i_ready,
    output o_valid, o_sum
  );

endinterface

// File: rtl/sum_block_accumulator.sv
// rtl/sum_block_accumulator.sv - accumulates fixed-size blocks of adder sums onto a valid/ready port
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-high reset
//   bus            sum_block_accumulator_if.slave (i_valid, i_C, i_ready, o_valid, o_sum)
//   i_clr_overrun  synchronous clear of o_overrun
//   o_overrun      sticky: at least one block total was dropped
//   o_fill         number of sums in the block currently being accumulated
module sum_block_accumulator
  import adder_pkg::*;
#(
  parameter int g_data_width = DATA_WIDTH_DEFAULT,
  parameter int g_block_len  = 4,
  parameter int g_sum_width  = sum_width(g_data_width, g_block_len)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  sum_block_accumulator_if.slave         bus,
  input  logic                           i_clr_overrun,
  output logic                           o_overrun,
  output logic [$clog2(g_block_len)-1:0] o_fill
);

  localparam int FW = $clog2(g_block_len);

  acc_state_t             r_state;
  logic [g_sum_width-1:0] r_acc;
  logic [FW-1:0]          r_fill;
  logic [g_sum_width-1:0] r_sum;
  logic                   r_valid;
  logic                   r_overrun;

  logic                   w_complete;
  logic [g_sum_width-1:0] w_total;
  logic                   w_overrun_ev;

  // The last sum of a block is added combinationally so the total is ready
  // on the same edge that captures it; acc restarts from zero next cycle.
  assign w_complete   = bus.i_valid && (r_fill == FW'(g_block_len - 1));
  assign w_total      = r_acc + g_sum_width'(bus.i_C);
  assign w_overrun_ev = w_complete && (r_state == ST_FULL) && !bus.i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_EMPTY;
      r_acc     <= '0;
      r_fill    <= '0;
      r_sum     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // i_C is only looked at under i_valid, so an undriven bus cannot leak in.
      if (bus.i_valid) begin
        if (w_complete) begin
          r_acc  <= '0;
          r_fill <= '0;
        end else begin
          r_acc  <= w_total;
          r_fill <= r_fill + FW'(1);
        end
      end

      unique case (r_state)
        ST_EMPTY: begin
          if (w_complete) begin
            r_sum   <= w_total;
            r_valid <= 1'b1;
            r_state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_complete) begin
            // Accepted this cycle: the slot frees up and is refilled at once.
            // Not accepted: the pending total wins and the new one is lost.
            if (bus.i_ready) begin
              r_sum <= w_total;
            end
          end else if (bus.i_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_EMPTY;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_EMPTY;
        end
      endcase

      // A fresh drop outranks a clear in the same cycle.
      if (w_overrun_ev) begin
        r_overrun <= 1'b1;
      end else if (i_clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.o_valid = r_valid;
  assign bus.o_sum   = r_sum;
  assign o_overrun   = r_overrun;
  assign o_fill      = r_fill;

`ifdef USE_VERILATOR
  a_hold_pending : assert property (@(posedge i_clk) disable iff (i_rst)
    bus.o_valid && !bus.i_ready |=> $stable(bus.o_sum) && bus.o_valid);

  a_fill_range : assert property (@(posedge i_clk) disable iff (i_rst)
    32'(r_fill) < g_block_len);

  c_overrun : cover property (@(posedge i_clk) disable iff (i_rst)
    w_overrun_ev);

  c_accept_and_complete : cover property (@(posedge i_clk) disable iff (i_rst)
    w_complete && (r_state == ST_FULL) && bus.i_ready);
`endif

endmodule

// File: tb/tb_sum_block_accumulator.sv
// tb/tb_sum_block_accumulator.sv - self-checking bench for sum_block_accumulator
module tb_sum_block_accumulator;

  localparam int DW = 3;
  localparam int BL = 4;
  localparam int SW = DW + 1 + $clog2(BL);
  localparam int FW = $clog2(BL);

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_clr_overrun = 1'b0;
  logic          o_overrun;
  logic [FW-1:0] o_fill;

  sum_block_accumulator_if #(.g_data_width(DW), .g_sum_width(SW)) bus ();

  sum_block_accumulator #(.g_data_width(DW), .g_block_len(BL)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .bus           (bus),
    .i_clr_overrun (i_clr_overrun),
    .o_overrun     (o_overrun),
    .o_fill        (o_fill)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Behavioural model: running block sum, count of sums in the block,
  // one pending total slot, sticky drop flag.
  int m_acc  = 0;
  int m_cnt  = 0;
  bit m_pend = 1'b0;
  int m_sum  = 0;
  bit m_ovr  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_pend = 1'b0; m_sum = 0; m_ovr = 1'b0;
  endtask

  // One clock of stimulus: drive, let the DUT and model see the edge, settle past negedge.
  task automatic step(input bit v, input int c, input bit rdy, input bit clr);
    bit comp;
    bit ovr_ev;
    int total;
    bus.i_valid   = v;
    bus.i_C       = v ? (DW+1)'(c) : (DW+1)'($urandom);
    bus.i_ready   = rdy;
    i_clr_overrun = clr;
    @(posedge i_clk);
    comp   = v && (m_cnt == BL - 1);
    total  = m_acc + c;
    ovr_ev = comp && m_pend && !rdy;
    if (v) begin
      if (comp) begin m_acc = 0; m_cnt = 0; end
      else begin m_acc = total; m_cnt++; end
    end
    if (comp) begin
      if (!m_pend || rdy) begin m_sum = total; m_pend = 1'b1; end
    end else if (m_pend && rdy) begin
      m_pend = 1'b0;
    end
    if (ovr_ev) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    @(negedge i_clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 0, rdy, 1'b0);
  endtask

  always @(negedge i_clk) begin
    if (chk_en) begin
      check("o_valid",   32'(bus.o_valid), 32'(m_pend));
      check("o_sum",     32'(bus.o_sum),   32'(m_sum[SW-1:0]));
      check("o_overrun", 32'(o_overrun),   32'(m_ovr));
      check("o_fill",    32'(o_fill),      32'(m_cnt));
    end
  end

  int seq_a[4] = '{3, 5, 7, 1};
  int seq_g[7] = '{2, -1, -1, 4, -1, 6, 8};
  int fill_g[7] = '{1, 1, 1, 2, 2, 3, 0};
  int seq_r[4] = '{1, 2, 3, 4};

  initial begin
    bus.i_valid = 1'b0;
    bus.i_C = '0;
    bus.i_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    #1 i_rst = 1'b0;
    check("reset_valid",   32'(bus.o_valid), 0);
    check("reset_sum",     32'(bus.o_sum),   0);
    check("reset_overrun", 32'(o_overrun),   0);
    check("reset_fill",    32'(o_fill),      0);
    chk_en = 1'b1;

    // 1: basic block
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq_a[i], 1'b1, 1'b0);
      if (i == 2) check("t1_valid_early", 32'(bus.o_valid), 0);
    end
    check("t1_valid", 32'(bus.o_valid), 1);
    check("t1_sum",   32'(bus.o_sum),   16);
    check("t1_fill",  32'(o_fill),      0);
    check("t1_model", 32'(m_sum),       16);
    idle(1'b1);
    check("t1_drop", 32'(bus.o_valid), 0);

    // 2: maximum adder results
    for (int i = 0; i < 4; i++) step(1'b1, 14, 1'b1, 1'b0);
    check("t2_sum", 32'(bus.o_sum), 56);
    idle(1'b1);

    // 3: gapped input
    check("t3_fill0", 32'(o_fill), 0);
    for (int i = 0; i < 7; i++) begin
      step(seq_g[i] >= 0, (seq_g[i] >= 0) ? seq_g[i] : 0, 1'b1, 1'b0);
      check("t3_fill", 32'(o_fill), 32'(fill_g[i]));
    end
    check("t3_sum", 32'(bus.o_sum), 20);
    idle(1'b1);

    // 4: backpressure and overrun
    for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0, 1'b0);
    check("t4_sum_a", 32'(bus.o_sum), 4);
    for (int i = 0; i < 4; i++) begin
      check("t4_ovr_pre", 32'(o_overrun), 0);
      step(1'b1, 2, 1'b0, 1'b0);
    end
    check("t4_sum_b", 32'(bus.o_sum), 4);
    check("t4_ovr",   32'(o_overrun), 1);
    idle(1'b1);
    check("t4_valid", 32'(bus.o_valid), 0);
    check("t4_ovr_sticky", 32'(o_overrun), 1);
    step(1'b0, 0, 1'b0, 1'b1);
    check("t4_clr", 32'(o_overrun), 0);

    // 5: acceptance coinciding with completion
    for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 3, 1'b0, 1'b0);
    step(1'b1, 3, 1'b1, 1'b0);
    check("t5_valid", 32'(bus.o_valid), 1);
    check("t5_sum",   32'(bus.o_sum),   12);
    check("t5_ovr",   32'(o_overrun),   0);
    idle(1'b1);

    // 6: asynchronous reset with a total pending and a partial block
    for (int i = 0; i < 4; i++) step(1'b1, 5, 1'b0, 1'b0);
    step(1'b1, 1, 1'b0, 1'b0);
    step(1'b1, 1, 1'b0, 1'b0);
    bus.i_valid = 1'b0;
    #2 i_rst = 1'b1;
    model_reset();
    #1;
    check("t6_valid", 32'(bus.o_valid), 0);
    check("t6_sum",   32'(bus.o_sum),   0);
    check("t6_fill",  32'(o_fill),      0);
    check("t6_ovr",   32'(o_overrun),   0);
    @(negedge i_clk);
    @(negedge i_clk);
    #1 i_rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, seq_r[i], 1'b1, 1'b0);
    check("t6_sum_after", 32'(bus.o_sum), 10);
    idle(1'b1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 14),
           $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
